// File: rtl/inst_mem_mp_if.sv
// Host-side bundle for inst_mem_mp: streaming load channel
// plus word readback.
interface inst_mem_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
);
  logic              host_start;
  logic [ADDR_W-1:0] host_base;
  logic              host_wvalid;
  logic [DATA_W-1:0] host_wdata;
  logic              host_wlast;
  logic              host_wready;
  logic [ADDR_W:0]   host_count;
  logic              host_wrap_err;
  logic              host_rd_en;
  logic [ADDR_W-1:0] host_rd_addr;
  logic [DATA_W-1:0] host_rd_data;
  logic              host_rd_valid;

  modport master (
    output host_start,
    output host_base,
    output host_wvalid,
    output host_wdata,
    output host_wlast,
    input  host_wready,
    input  host_count,
    input  host_wrap_err,
    output host_rd_en,
    output host_rd_addr,
    input  host_rd_data,
    input  host_rd_valid
  );

  modport slave (
    input  host_start,
    input  host_base,
    input  host_wvalid,
    input  host_wdata,
    input  host_wlast,
    output host_wready,
    output host_count,
    output host_wrap_err,
    input  host_rd_en,
    input  host_rd_addr,
    output host_rd_data,
    output host_rd_valid
  );
endinterface

// File: rtl/inst_mem_mp.sv
// Multi-port GPU instruction memory with host streaming loader
// and a post-reset clear sweep that fills every word with HALT.
module inst_mem_mp #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 128,
  parameter int                ADDR_W    = 7,
  parameter int                NPORTS    = 2,
  parameter logic [DATA_W-1:0] FILL_WORD = 32'hF0000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     busy,
  inst_mem_mp_if.slave             host,
  input  logic [NPORTS-1:0]        fetch_en,
  input  logic [NPORTS*ADDR_W-1:0] fetch_pc,
  output logic [NPORTS*DATA_W-1:0] fetch_instr,
  output logic [NPORTS-1:0]        fetch_valid
);

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    LOAD
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic              start;
  logic              accept;
  logic              active;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  always_comb begin
    state_nx         = state;
    busy             = 1'b0;
    host.host_wready = 1'b0;
    start            = 1'b0;
    accept           = 1'b0;
    we               = 1'b0;
    waddr            = clr_ptr;
    wdata            = FILL_WORD;
    unique case (state)
      CLEAR: begin
        busy = 1'b1;
        we   = 1'b1;
        if (clr_ptr == LAST_ADDR)
          state_nx = IDLE;
      end
      IDLE: begin
        start = host.host_start;
        if (start)
          state_nx = LOAD;
      end
      LOAD: begin
        host.host_wready = 1'b1;
        start  = host.host_start;
        // a restart wins over a beat presented in the same cycle
        accept = host.host_wvalid && !host.host_start;
        if (accept) begin
          we    = 1'b1;
          waddr = wr_ptr;
          wdata = host.host_wdata;
          if (host.host_wlast)
            state_nx = IDLE;
        end
      end
      default: state_nx = CLEAR;
    endcase
  end

  assign active = (state != CLEAR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= CLEAR;
      clr_ptr            <= '0;
      wr_ptr             <= '0;
      host.host_count    <= '0;
      host.host_wrap_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == CLEAR)
        clr_ptr <= clr_ptr + 1'b1;
      if (start) begin
        wr_ptr             <= host.host_base;
        host.host_count    <= '0;
        host.host_wrap_err <= 1'b0;
      end else if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (host.host_count == FULL_CNT)
          host.host_wrap_err <= 1'b1;
        else
          host.host_count <= host.host_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we && rst_n)
      mem[waddr] <= wdata;
  end

  // reads sample the array before this edge's write: old data wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      host.host_rd_valid <= 1'b0;
      host.host_rd_data  <= '0;
      fetch_valid        <= '0;
      fetch_instr        <= {NPORTS{FILL_WORD}};
    end else begin
      host.host_rd_valid <= active && host.host_rd_en;
      if (active && host.host_rd_en)
        host.host_rd_data <= mem[host.host_rd_addr];
      for (int k = 0; k < NPORTS; k++) begin
        fetch_valid[k] <= active && fetch_en[k];
        if (active && fetch_en[k])
          fetch_instr[k*DATA_W +: DATA_W] <=
            mem[fetch_pc[k*ADDR_W +: ADDR_W]];
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_mp.sv
// Bench for inst_mem_mp: vector table, directed corner sequences
// and randomized traffic against a word-level memory model.
module tb_inst_mem_mp;
  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 128;
  localparam int          ADDR_W = 7;
  localparam int          NPORTS = 2;
  localparam logic [31:0] FILL   = 32'hF0000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [1:0]  fetch_en;
  logic [13:0] fetch_pc;
  logic [63:0] fetch_instr;
  logic [1:0]  fetch_valid;

  always #5 clk = ~clk;

  inst_mem_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) hif ();

  inst_mem_mp #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .NPORTS(NPORTS), .FILL_WORD(FILL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .busy(busy),
    .host(hif),
    .fetch_en(fetch_en),
    .fetch_pc(fetch_pc),
    .fetch_instr(fetch_instr),
    .fetch_valid(fetch_valid)
  );

  typedef struct {
    logic        st;
    logic [6:0]  base;
    logic        wv;
    logic [31:0] wd;
    logic        wl;
    logic        rd;
    logic [6:0]  ra;
    logic        e_wr;
    logic [7:0]  e_cnt;
    logic        e_rdv;
    logic [31:0] e_rdd;
  } vec_t;

  vec_t tbl[12];

  // reference: memory as a plain array, session as pointer/count
  logic [31:0] mem_m[DEPTH];
  bit          m_load;
  int          m_ptr;
  int          m_cnt;
  bit          m_err;
  logic [31:0] m_rdd;
  bit          m_rdv;
  logic [31:0] m_fi[2];
  logic [1:0]  m_fv;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic clr_in();
    hif.host_start   = 1'b0;
    hif.host_base    = '0;
    hif.host_wvalid  = 1'b0;
    hif.host_wdata   = '0;
    hif.host_wlast   = 1'b0;
    hif.host_rd_en   = 1'b0;
    hif.host_rd_addr = '0;
    fetch_en         = '0;
    fetch_pc         = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = FILL;
    m_load = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
    m_rdd = '0; m_rdv = 0;
    m_fi[0] = FILL; m_fi[1] = FILL; m_fv = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    m_rdv = hif.host_rd_en;
    if (hif.host_rd_en) m_rdd = mem_m[int'(hif.host_rd_addr)];
    for (int k = 0; k < NPORTS; k++) begin
      m_fv[k] = fetch_en[k];
      if (fetch_en[k]) m_fi[k] = mem_m[int'(fetch_pc[k*ADDR_W +: ADDR_W])];
    end
    if (hif.host_start) begin
      m_load = 1; m_ptr = int'(hif.host_base); m_cnt = 0; m_err = 0;
    end else if (m_load && hif.host_wvalid) begin
      mem_m[m_ptr] = hif.host_wdata;
      m_ptr = (m_ptr + 1) % DEPTH;
      if (m_cnt == DEPTH) m_err = 1;
      else m_cnt++;
      if (hif.host_wlast) m_load = 0;
    end
    step();
    chk("m_busy", 64'(busy), 64'(0));
    chk("m_rd_valid", 64'(hif.host_rd_valid), 64'(m_rdv));
    chk("m_rd_data", 64'(hif.host_rd_data), 64'(m_rdd));
    chk("m_fetch_valid", 64'(fetch_valid), 64'(m_fv));
    chk("m_fetch_instr", fetch_instr, {m_fi[1], m_fi[0]});
    chk("m_wready", 64'(hif.host_wready), 64'(m_load));
    chk("m_count", 64'(hif.host_count), 64'(m_cnt));
    chk("m_wrap_err", 64'(hif.host_wrap_err), 64'(m_err));
  endtask

  initial begin
    int n;
    bit bad;
    logic [31:0] bw[3];
    logic [31:0] lastw;
    logic [31:0] old;
    int ra[3];

    tbl[0]  = '{1, 10, 0, 32'h0,        0, 0, 0,  1, 0, 0, 32'h0};
    tbl[1]  = '{0, 0,  1, 32'hAA000001, 0, 0, 0,  1, 1, 0, 32'h0};
    tbl[2]  = '{0, 0,  1, 32'hAA000002, 0, 0, 0,  1, 2, 0, 32'h0};
    tbl[3]  = '{0, 0,  1, 32'hAA000003, 0, 0, 0,  1, 3, 0, 32'h0};
    tbl[4]  = '{0, 0,  1, 32'hAA000004, 1, 0, 0,  0, 4, 0, 32'h0};
    tbl[5]  = '{0, 0,  0, 32'h0,        0, 1, 10, 0, 4, 1, 32'hAA000001};
    tbl[6]  = '{0, 0,  0, 32'h0,        0, 1, 11, 0, 4, 1, 32'hAA000002};
    tbl[7]  = '{0, 0,  0, 32'h0,        0, 1, 12, 0, 4, 1, 32'hAA000003};
    tbl[8]  = '{0, 0,  0, 32'h0,        0, 1, 13, 0, 4, 1, 32'hAA000004};
    tbl[9]  = '{0, 0,  0, 32'h0,        0, 0, 0,  0, 4, 0, 32'hAA000004};
    tbl[10] = '{0, 0,  1, 32'hDEADBEEF, 1, 0, 0,  0, 4, 0, 32'hAA000004};
    tbl[11] = '{0, 0,  0, 32'h0,        0, 1, 14, 0, 4, 1, FILL};
    ra[0] = 126; ra[1] = 127; ra[2] = 0;

    clr_in();
    model_reset();
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_busy", 64'(busy), 64'(1));
    chk("rst_wready", 64'(hif.host_wready), 64'(0));
    chk("rst_count", 64'(hif.host_count), 64'(0));
    chk("rst_wrap_err", 64'(hif.host_wrap_err), 64'(0));
    chk("rst_rd_valid", 64'(hif.host_rd_valid), 64'(0));
    chk("rst_rd_data", 64'(hif.host_rd_data), 64'(0));
    chk("rst_fetch_valid", 64'(fetch_valid), 64'(0));
    chk("rst_fetch_instr", fetch_instr, {FILL, FILL});

    // everything requested during the sweep must be ignored
    hif.host_start = 1'b1; hif.host_base = 7'd3;
    hif.host_wvalid = 1'b1; hif.host_wdata = 32'h12345678;
    hif.host_rd_en = 1'b1; fetch_en = 2'b11; fetch_pc = 14'h0A5;
    rst_n = 1'b1;
    n = 0; bad = 0;
    while (busy && n < 300) begin
      step();
      n++;
      if (fetch_valid != 0 || hif.host_rd_valid || hif.host_wready)
        bad = 1;
    end
    chk("sweep_cycles", 64'(n), 64'(DEPTH));
    chk("sweep_ignores_inputs", 64'(bad), 64'(0));
    clr_in();

    fetch_en = 2'b01; fetch_pc[6:0] = 7'd5;
    cyc();
    chk("fetch_pc5_instr", 64'(fetch_instr[31:0]), 64'(FILL));
    chk("fetch_pc5_valid", 64'(fetch_valid[0]), 64'(1));
    clr_in();

    for (int i = 0; i < 12; i++) begin
      hif.host_start   = tbl[i].st;
      hif.host_base    = tbl[i].base;
      hif.host_wvalid  = tbl[i].wv;
      hif.host_wdata   = tbl[i].wd;
      hif.host_wlast   = tbl[i].wl;
      hif.host_rd_en   = tbl[i].rd;
      hif.host_rd_addr = tbl[i].ra;
      cyc();
      chk($sformatf("tbl%0d_wready", i), 64'(hif.host_wready), 64'(tbl[i].e_wr));
      chk($sformatf("tbl%0d_count", i), 64'(hif.host_count), 64'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_rd_valid", i), 64'(hif.host_rd_valid), 64'(tbl[i].e_rdv));
      chk($sformatf("tbl%0d_rd_data", i), 64'(hif.host_rd_data), 64'(tbl[i].e_rdd));
    end
    clr_in();

    hif.host_start = 1'b1; hif.host_base = 7'd126;
    cyc(); clr_in();
    for (int j = 0; j < 3; j++) begin
      hif.host_wvalid = 1'b1;
      hif.host_wdata = $urandom;
      hif.host_wlast = (j == 2);
      bw[j] = hif.host_wdata;
      cyc(); clr_in();
    end
    chk("wrap3_err", 64'(hif.host_wrap_err), 64'(0));
    for (int j = 0; j < 3; j++) begin
      hif.host_rd_en = 1'b1; hif.host_rd_addr = 7'(ra[j]);
      cyc(); clr_in();
      chk($sformatf("wrap3_rd%0d", ra[j]), 64'(hif.host_rd_data), 64'(bw[j]));
    end

    hif.host_start = 1'b1; hif.host_base = 7'd0;
    cyc(); clr_in();
    lastw = '0;
    for (int j = 0; j < 129; j++) begin
      hif.host_wvalid = 1'b1;
      hif.host_wdata = $urandom;
      hif.host_wlast = (j == 128);
      lastw = hif.host_wdata;
      cyc(); clr_in();
    end
    chk("wrap129_err", 64'(hif.host_wrap_err), 64'(1));
    chk("wrap129_count", 64'(hif.host_count), 64'(DEPTH));
    hif.host_rd_en = 1'b1; hif.host_rd_addr = 7'd0;
    cyc(); clr_in();
    chk("wrap129_rd0", 64'(hif.host_rd_data), 64'(lastw));

    old = mem_m[20];
    hif.host_start = 1'b1; hif.host_base = 7'd20;
    cyc(); clr_in();
    hif.host_wvalid = 1'b1; hif.host_wdata = 32'h55555555;
    hif.host_wlast = 1'b1;
    fetch_en = 2'b11; fetch_pc = {7'd20, 7'd20};
    cyc(); clr_in();
    chk("rdw_old", fetch_instr, {old, old});
    fetch_en = 2'b11; fetch_pc = {7'd20, 7'd20};
    cyc(); clr_in();
    chk("rdw_new", fetch_instr, {2{32'h55555555}});

    for (int j = 0; j < 5; j++) begin
      cyc();
      chk("idle_fetch_valid", 64'(fetch_valid), 64'(0));
      chk("idle_fetch_hold", fetch_instr, {2{32'h55555555}});
    end

    for (int i = 0; i < 400; i++) begin
      hif.host_start   = ($urandom_range(0, m_load ? 39 : 7) == 0);
      hif.host_base    = 7'($urandom);
      hif.host_wvalid  = ($urandom % 4 != 0);
      hif.host_wdata   = $urandom;
      hif.host_wlast   = ($urandom % 12 == 0);
      hif.host_rd_en   = 1'($urandom);
      hif.host_rd_addr = ($urandom % 4 == 0) ? 7'(m_ptr) : 7'($urandom);
      fetch_en         = 2'($urandom);
      for (int k = 0; k < NPORTS; k++)
        fetch_pc[k*ADDR_W +: ADDR_W] =
          ($urandom % 4 == 0) ? 7'(m_ptr) : 7'($urandom);
      cyc();
    end
    clr_in();

    hif.host_start = 1'b1; hif.host_base = 7'd40;
    cyc(); clr_in();
    for (int j = 0; j < 2; j++) begin
      hif.host_wvalid = 1'b1; hif.host_wdata = 32'hBB000000 + 32'(j);
      cyc(); clr_in();
    end
    hif.host_wvalid = 1'b1; hif.host_wdata = 32'hBB000002;
    rst_n = 1'b0;
    step();
    chk("midrst_busy", 64'(busy), 64'(1));
    chk("midrst_wready", 64'(hif.host_wready), 64'(0));
    chk("midrst_count", 64'(hif.host_count), 64'(0));
    clr_in();
    model_reset();
    rst_n = 1'b1;
    n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    chk("midrst_sweep_cycles", 64'(n), 64'(DEPTH));
    hif.host_rd_en = 1'b1; hif.host_rd_addr = 7'd40;
    cyc(); clr_in();
    chk("midrst_rd_base", 64'(hif.host_rd_data), 64'(FILL));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/inst_mem_mp.md
# inst_mem_mp

Parametrised multi-port instruction memory for the GPU core, with a host streaming loader and a hardware clear sequencer. The host streams a program into consecutive addresses through a valid/ready port and can read words back for verification. NPORTS independent fetch ports serve per-warp program counters with 1-cycle registered latency. After every reset the block sweeps the whole array to FILL_WORD (HALT) before accepting host writes or fetches.

## Interface
- DATA_W, 32, instruction width in bits
- DEPTH, 128, number of words; must be a power of two, minimum 2
- ADDR_W, 7, address width; must equal log2(DEPTH)
- NPORTS, 2, number of GPU fetch ports, minimum 1
- FILL_WORD, 32'hF0000000, value written by the clear sweep (HALT)

- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- busy  out  1  high while the clear sweep runs
- host_start  in  1  pulse; opens a load session at host_base
- host_base  in  ADDR_W  first write address of the session
- host_wvalid  in  1  write beat valid
- host_wdata  in  DATA_W  write beat data
- host_wlast  in  1  qualifies the final beat of the session
- host_wready  out  1  high in LOAD only
- host_count  out  ADDR_W+1  beats accepted in the current or last session
- host_wrap_err  out  1  sticky: session accepted more than DEPTH beats
- host_rd_en  in  1  readback request
- host_rd_addr  in  ADDR_W  readback address
- host_rd_data  out  DATA_W  readback data, registered
- host_rd_valid  out  1  high the cycle after an accepted host_rd_en
- fetch_en  in  NPORTS  per-port fetch enable
- fetch_pc  in  NPORTS*ADDR_W  per-port address; port k at bits [k*ADDR_W +: ADDR_W]
- fetch_instr  out  NPORTS*DATA_W  per-port instruction, registered
- fetch_valid  out  NPORTS  per-port valid, registered

## Operation
FSM states are CLEAR, IDLE, and LOAD.

- **CLEAR**
  - Entered on every cycle with rst_n=0. The clear pointer resets to 0.
  - After reset releases, one word is written per cycle: mem[clr_ptr] <= FILL_WORD.
  - On clr_ptr==DEPTH-1 the state moves to IDLE.
  - busy=1 throughout. host_start, host_wvalid, host_rd_en and fetch_en are ignored; no valids assert.
- **IDLE**
  - host_start moves to LOAD. On that transition: wr_ptr <= host_base, host_count <= 0, host_wrap_err <= 0.
- **LOAD**
  - host_wready=1. A beat is accepted when host_wvalid=1.
  - Each accepted beat does mem[wr_ptr] <= host_wdata, wr_ptr <= wr_ptr+1 (wraps modulo DEPTH), and increments host_count.
  - If an accepted beat finds host_count==DEPTH, host_wrap_err sets, the write still happens, and host_count saturates at DEPTH.
  - An accepted beat with host_wlast=1 is written, and the state returns to IDLE next cycle.
  - host_wlast without host_wvalid is ignored.
  - host_start while in LOAD restarts the session at the new host_base; any beat in that same cycle is dropped.
- **Readback** (IDLE or LOAD)
  - host_rd_data <= mem[host_rd_addr], and host_rd_valid <= 1.
  - When not requested, host_rd_valid <= 0 and host_rd_data holds its value.
- **Fetch** (IDLE or LOAD), per port k
  - If fetch_en[k]: fetch_instr[k] <= mem[fetch_pc[k]], and fetch_valid[k] <= 1.
  - Otherwise fetch_valid[k] <= 0 and fetch_instr[k] holds its value.
  - All ports are fully independent, and may address the same word in the same cycle.
- **Read-during-write:** any read (fetch or readback) of an address being written in the same cycle returns the old contents.

## Timing
- **Reset values (cycle after rst_n=0 is sampled):**
  - state=CLEAR, busy=1, host_wready=0, host_count=0, host_wrap_err=0
  - host_rd_valid=0, host_rd_data=0
  - fetch_valid=0, every fetch_instr lane=FILL_WORD
- Memory contents are not reset directly; the CLEAR sweep overwrites them.
- **Clear duration:** busy stays high for exactly DEPTH cycles after the first cycle with rst_n=1. busy falls, and host_wready may rise, on cycle DEPTH.
- **Reset mid-operation:** rst_n=0 during LOAD or CLEAR aborts the operation. The session's partial writes remain until the sweep overwrites them; the sweep restarts from address 0.
- **Latencies:**
  - Host write: visible to any read issued the cycle after acceptance.
  - Fetch and readback: data is valid exactly 1 cycle after the enable.
- **Throughput:**
  - One host beat per cycle in LOAD.
  - NPORTS fetches plus one readback per cycle.

## Test plan
- **Reset sweep:** deassert rst_n after 3 cycles, then fetch_pc=5 on port 0 after busy falls. Required: busy high for exactly 128 cycles, then fetch_instr[0]=F0000000 with fetch_valid[0]=1.
- **Load and readback:** host_base=10, stream 4 beats (AA000001..AA000004) with wlast on the 4th. Required: host_count=4, return to IDLE, readback of addresses 10..13 matches the beats 1 cycle after each request.
- **Wrap:** host_base=126, stream 3 beats. Required: beats land at 126, 127 and 0, host_wrap_err=0. Then stream 129 beats from base 0. Required: host_wrap_err=1, host_count=128.
- **Multi-port fetch with read-during-write:**
  - Ports 0 and 1 fetch address 20 while a beat writes 55555555 to address 20. Required: both ports return the old word.
  - Refetch next cycle. Required: both ports return 55555555.
- **Backpressure/idle:** fetch_en low for 5 cycles. Required: fetch_valid=0 and fetch_instr holds its last value. A beat with host_wvalid=1 in IDLE. Required: host_wready=0 and memory unchanged.
- **Reset mid-load:** assert rst_n=0 after 2 of 6 beats. Required: busy=1, host_wready=0, and after the sweep address host_base reads F0000000.
